pulse_gen_multi: RTL and testbench

Multi-channel, parametrised trigger-to-load pulse generator. Each channel watches a level trigger. On a rising edge it waits a programmable number of clock cycles, then drives a load pulse of programmable width. The channel then stays locked out until its trigger is seen low. The block sits between slow control sources (push-buttons, handshake levels, step requests) and register/load enables in the soft-CPU datapath, and replaces per-signal single-shot pulse generators.

---
 rtl/pulse_gen_multi.sv | 112 +++++++++++
 tb/tb_pulse_gen_multi.sv | 117 +++++++++++
 2 files changed

// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: per-channel trigger-to-load pulse generator with delay, width and re-arm lockout.
// Define PULSE_GEN_SYNC_EN to insert a two-flop synchroniser on every trigger bit.
module pulse_gen_multi #(
    parameter int CHANNELS = 4,
    parameter int DELAY    = 1,
    parameter int WIDTH    = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trigger,
    output logic [CHANNELS-1:0] load,
    output logic [CHANNELS-1:0] busy,
    output logic                any_load
);
    localparam int MX = (DELAY > WIDTH) ? DELAY : WIDTH;
    localparam int CW = $clog2(MX) + 1;
    localparam logic [CW-1:0] DLY = CW'(DELAY - 1);
    localparam logic [CW-1:0] WID = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, WAIT, PULSE, HOLD} state_t;

    logic [CHANNELS-1:0] trg;
    logic [CHANNELS-1:0] load_d;
    logic [CHANNELS-1:0] load_q;
    logic [CHANNELS-1:0] busy_q;
    logic                any_load_q;

`ifdef PULSE_GEN_SYNC_EN
    logic [CHANNELS-1:0] s1_q;
    logic [CHANNELS-1:0] s2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= trigger;
            s2_q <= s1_q;
        end
    end

    assign trg = s2_q;
`else
    assign trg = trigger;
`endif

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            state_t          state_q, state_d;
            logic [CW-1:0]   cnt_q, cnt_d;

            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                load_d[i] = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (trg[i]) begin
                            state_d = WAIT;
                            cnt_d   = DLY;
                        end
                    end
                    WAIT: begin
                        if (cnt_q == '0) begin
                            state_d   = PULSE;
                            cnt_d     = WID;
                            load_d[i] = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    PULSE: begin
                        if (cnt_q == '0) begin
                            state_d = HOLD;
                        end else begin
                            cnt_d     = cnt_q - 1'b1;
                            load_d[i] = 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!trg[i]) state_d = IDLE;
                    end
                endcase
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    load_q[i] <= 1'b0;
                    busy_q[i] <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    load_q[i] <= load_d[i];
                    busy_q[i] <= (state_d != IDLE);
                end
            end
        end
    endgenerate

    // Registered from next-state loads so it lines up with load, not one cycle behind.
    always_ff @(posedge clock) begin
        if (reset) any_load_q <= 1'b0;
        else       any_load_q <= |load_d;
    end

    assign load     = load_q;
    assign busy     = busy_q;
    assign any_load = any_load_q;
endmodule

// File: tb/tb_pulse_gen_multi.sv
// tb_pulse_gen_multi: directed checks of pulse_gen_multi across four parameter sets.
module tb_pulse_gen_multi;
`ifdef PULSE_GEN_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] trig_a = '0, trig_b = '0, trig_c = '0, trig_d = '0;
    logic [3:0] load_a, load_b, load_c, load_d;
    logic [3:0] busy_a, busy_b, busy_c, busy_d;
    logic       any_a, any_b, any_c, any_d;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pulse_gen_multi #(.CHANNELS(4), .DELAY(1), .WIDTH(1)) u_a (
        .clock(clock), .reset(reset), .trigger(trig_a), .load(load_a), .busy(busy_a), .any_load(any_a));
    pulse_gen_multi #(.CHANNELS(4), .DELAY(5), .WIDTH(3)) u_b (
        .clock(clock), .reset(reset), .trigger(trig_b), .load(load_b), .busy(busy_b), .any_load(any_b));
    pulse_gen_multi #(.CHANNELS(4), .DELAY(2), .WIDTH(2)) u_c (
        .clock(clock), .reset(reset), .trigger(trig_c), .load(load_c), .busy(busy_c), .any_load(any_c));
    pulse_gen_multi #(.CHANNELS(4), .DELAY(1), .WIDTH(8)) u_d (
        .clock(clock), .reset(reset), .trigger(trig_d), .load(load_d), .busy(busy_d), .any_load(any_d));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        trig_a = '0; trig_b = '0; trig_c = '0; trig_d = '0;
        for (int j = 0; j < n; j++) tick();
    endtask

    initial begin
        int pulses;
        logic prev;
        int r;
        tick();
        tick();
        chk("rst_load", {load_a, load_b, load_c, load_d}, 16'h0);
        chk("rst_busy", {busy_a, busy_b, busy_c, busy_d}, 16'h0);
        chk("rst_any", {any_a, any_b, any_c, any_d}, 4'h0);
        reset = 1'b0;
        idle(3);

        // Baseline single pulse: trigger[0] held for 20 edges.
        for (int e = 0; e < 30; e++) begin
            trig_a[0] = (e < 20);
            tick();
            chk($sformatf("a_load_e%0d", e), load_a, {3'b0, e == SL + 1});
            chk($sformatf("a_busy_e%0d", e), busy_a, {3'b0, e >= SL && e < 20 + SL});
            chk($sformatf("a_any_e%0d", e), any_a, e == SL + 1);
        end
        idle(4);

        // Long delay/width, trigger dropped after two edges.
        for (int e = 0; e < 14; e++) begin
            trig_b[2] = (e < 2);
            tick();
            chk($sformatf("b_load_e%0d", e), load_b, {1'b0, e >= SL + 5 && e <= SL + 7, 2'b0});
            chk($sformatf("b_busy_e%0d", e), busy_b, {1'b0, e >= SL && e <= SL + 8, 2'b0});
        end
        idle(4);

        // Held trigger, one-cycle low, re-raise: exactly two pulses.
        pulses = 0;
        prev = 1'b0;
        for (int e = 0; e < 66; e++) begin
            trig_c[1] = (e != 50);
            tick();
            chk($sformatf("c_load_e%0d", e), load_c,
                {2'b0, (e >= SL + 2 && e <= SL + 3) || (e >= SL + 53 && e <= SL + 54), 1'b0});
            if (load_c[1] && !prev) pulses++;
            prev = load_c[1];
        end
        chk("c_pulses", pulses, 2);
        idle(6);

        // Independent channels: 0 and 3 together, 1 one edge later.
        for (int e = 0; e < 10; e++) begin
            trig_a = {e < 8, 1'b0, e >= 1 && e < 9, e < 8};
            tick();
            chk($sformatf("d_load_e%0d", e), load_a, {e == SL + 1, 1'b0, e == SL + 2, e == SL + 1});
            chk($sformatf("d_any_e%0d", e), any_a, e == SL + 1 || e == SL + 2);
        end
        idle(6);

        // Reset three cycles into an 8-wide pulse with trigger still high.
        r = 2 * SL + 5;
        for (int e = 0; e < 26; e++) begin
            trig_d[0] = 1'b1;
            reset = (e == SL + 4);
            tick();
            chk($sformatf("e_load_e%0d", e), load_d,
                {3'b0, (e >= SL + 1 && e <= SL + 3) || (e >= r + 1 && e <= r + 8)});
            if (e == SL + 4) chk("e_busy_rst", busy_d, 4'h0);
        end
        reset = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
